// File: rtl/random2_lfsr_if.sv
// Output bundle of the 2-bit pseudo-random source.
interface random2_lfsr_if;
    logic [1:0] random;

    modport master (output random);
    modport slave  (input  random);
endinterface

// File: rtl/random2_lfsr.sv
// Free-running 2-bit pseudo-random source for the VGA subsystem.
// A 16-bit maximal-length Fibonacci LFSR (x^16+x^14+x^13+x^11+1) advances
// every clock. The two LSBs of the state are exported with no pipeline.
module random2_lfsr #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int unsigned WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    random2_lfsr_if.master bus
);

    // A zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] s_next;
    logic             fb;

    // Feedback, shift, and recovery from the unreachable all-zero state.
    always_comb begin
        fb     = s[15] ^ s[13] ^ s[12] ^ s[10];
        s_next = {s[WIDTH-2:0], fb};
        if (s == '0) begin
            s_next = SEED_EFF;
        end
    end

    // State register, asynchronously reloaded with the seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= SEED_EFF;
        end else begin
            s <= s_next;
        end
    end

    assign bus.random = s[1:0];

endmodule

// File: tb/tb_random2_lfsr.sv
// Directed self-checking bench for random2_lfsr.
module tb_random2_lfsr;

    logic clk;
    logic rst;

    random2_lfsr_if bus_def ();
    random2_lfsr_if bus_one ();
    random2_lfsr_if bus_zero ();

    random2_lfsr #(.SEED(16'hACE1), .WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_def)
    );

    random2_lfsr #(.SEED(16'h0001), .WIDTH(16)) dut_one (
        .clk (clk),
        .rst (rst),
        .bus (bus_one)
    );

    random2_lfsr #(.SEED(16'h0000), .WIDTH(16)) dut_zero (
        .clk (clk),
        .rst (rst),
        .bus (bus_zero)
    );

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int          count;
        int          zero_seen;
        int          hist [4];
        logic [15:0] st;

        // Reset before any clock edge.
        rst = 1'b1;
        #2;
        check("rst_state",       dut.s,                  16'hACE1);
        check("rst_random",      {14'd0, bus_def.random}, 16'h0001);
        check("one_rst_random",  {14'd0, bus_one.random}, 16'h0001);
        check("zero_seed_state", dut_zero.s,             16'h0001);

        @(negedge clk);
        rst = 1'b0;

        @(posedge clk); #1;
        check("step1_state",  dut.s,                   16'h59C3);
        check("step1_random", {14'd0, bus_def.random}, 16'h0003);
        check("one_step1",    dut_one.s,               16'h0002);
        check("one_rand1",    {14'd0, bus_one.random}, 16'h0002);
        check("zero_step1",   dut_zero.s,              16'h0002);
        @(posedge clk); #1;
        check("step2_state",  dut.s,                   16'hB387);
        check("step2_random", {14'd0, bus_def.random}, 16'h0003);
        check("one_step2",    dut_one.s,               16'h0004);
        check("one_rand2",    {14'd0, bus_one.random}, 16'h0000);
        @(posedge clk); #1;
        check("step3_state",  dut.s,                   16'h670F);
        check("step3_random", {14'd0, bus_def.random}, 16'h0003);

        // Period and histogram from a fresh reset.
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        count     = 0;
        zero_seen = 0;
        for (int i = 0; i < 4; i++) hist[i] = 0;
        do begin
            @(posedge clk); #1;
            count++;
            st = dut.s;
            if (st == 16'h0000) zero_seen++;
            hist[bus_def.random]++;
        end while (st != 16'hACE1 && count < 70000);
        check("period",     count[15:0] , 16'hFFFF);
        check("period_hi",  16'(count >> 16), 16'h0000);
        check("zero_state", zero_seen[15:0], 16'h0000);
        check("hist00",     hist[0][15:0], 16'd16383);
        check("hist01",     hist[1][15:0], 16'd16384);
        check("hist10",     hist[2][15:0], 16'd16384);
        check("hist11",     hist[3][15:0], 16'd16384);

        // Asynchronous reset between edges.
        repeat (100) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_state",  dut.s,                   16'hACE1);
        check("async_random", {14'd0, bus_def.random}, 16'h0001);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("restart1", {14'd0, bus_def.random}, 16'h0003);
        check("restart1_state", dut.s, 16'h59C3);
        @(posedge clk); #1;
        check("restart2", {14'd0, bus_def.random}, 16'h0003);
        @(posedge clk); #1;
        check("restart3", {14'd0, bus_def.random}, 16'h0003);
        check("restart3_state", dut.s, 16'h670F);

        // Lock-up recovery from a deposited all-zero state.
        @(negedge clk);
        dut.s = 16'h0000;
        #1;
        check("lock_deposit", dut.s, 16'h0000);
        @(posedge clk); #1;
        check("lock_state",  dut.s,                   16'hACE1);
        check("lock_random", {14'd0, bus_def.random}, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/random2_lfsr.md
Name: random2_lfsr

Overview:
- Free-running 2-bit pseudo-random number source for the VGA subsystem, used for random choices such as colour or sprite selection.
- Built on a 16-bit maximal-length Fibonacci LFSR that advances once per clock; the 2 LSBs of the state are exported.
- No enable or handshake; a new value is available every cycle.

Parameters:
- SEED, 16'hACE1, LFSR state loaded on reset. Must be nonzero; SEED==0 is treated as 16'h0001.
- WIDTH, 16, LFSR state width. Fixed at 16; the tap set below is defined only for 16.

Ports:
- clk  input  1  system clock; state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- random  output  2  current pseudo-random value, equal to state[1:0].

Behaviour:
- State: 16-bit register s.
- Reset: while rst=1, s = SEED (or 16'h0001 if SEED==0), applied asynchronously. The output is valid immediately from the register, so random = SEED[1:0] (01 for the default seed).
- Update (each rising clk with rst=0):
  - fb = s[15]^s[13]^s[12]^s[10] (polynomial x^16+x^14+x^13+x^11+1).
  - s_next = {s[14:0], fb}.
- Lock-up guard: if s==16'h0000 at a clock edge (for example after an SEU), s_next = SEED (sanitised) instead of the shift result. This state is unreachable in normal operation.
- Output: random = s[1:0], driven combinationally from the register. No extra pipeline; latency is 0 cycles from state to output.
- Sequence:
  - Period is exactly 65535 clocks; the all-zero state is never visited.
  - Over one period, random=00 occurs 16383 times; 01, 10 and 11 occur 16384 times each.
- Reset mid-operation: asserting rst at any time returns s to SEED asynchronously, without waiting for a clock edge. Release is synchronous in effect: the first shift happens on the first rising edge with rst=0.
- Deterministic: the same seed always gives the same sequence. There is no external entropy.
- Synthesis: no latches. The only storage is the 16 flip-flops of s, and all flops have async reset.

Test Plan:
- Reset, default seed: assert rst -> s=16'hACE1, random=2'b01 before any clock edge.
- Three rising edges after release -> states 59C3, B387, 670F; random = 11, 11, 11.
- SEED=16'h0001: after reset random=01; one edge -> s=16'h0002, random=10; second edge -> s=16'h0004, random=00.
- Period check: run from reset and count edges until s returns to 16'hACE1 -> exactly 65535, with s never 0.
  - Histogram over that window: 00=16383; 01, 10, 11 = 16384 each.
- Async reset mid-run: after 100 clocks, pulse rst between clock edges -> random returns to 01 immediately, without a clock edge.
  - The sequence then restarts 11, 11, 11.
- Lock-up recovery: force s=16'h0000 via a hierarchical deposit, then apply one edge -> s=16'hACE1, random=01.
